reed_solomon_decoder_dsm_writer: RTL and testbench
==================================================

Name: reed_solomon_decoder_dsm_writer

Overview:
- AFU-to-host status path: the counterpart of the host-to-AFU CSR path.
- On decoder completion, writes one 64-byte status line to host memory at the DSM base that software programmed through the CSRs.
- Issues the write on the CCI-P c1 (write) TX channel and waits for the matching c1 RX write response.
- Provides the run cycle count and completion handshake software polls for.

Parameters:
- MDATA_W, 16, width of request/response mdata tag
- ADDR_W, 42, cache-line address width (matches hc_dsm_base)
- CNT_W, 64, run cycle counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- hc_dsm_base  in  ADDR_W  DSM cache-line address from CSR block; 0 = not programmed
- run_start  in  1  one-cycle pulse: decoder began a job
- run_done  in  1  one-cycle pulse: decoder finished a job
- err_count  in  32  corrected-symbol count, valid with run_done
- fail_flag  in  1  uncorrectable block seen, valid with run_done
- c1_almfull  in  1  c1 TX almost-full
- c1_req_valid  out  1  write request valid (single-cycle per request)
- c1_req_addr  out  ADDR_W  write cache-line address
- c1_req_mdata  out  MDATA_W  write tag
- c1_req_data  out  512  write data
- c1_rsp_valid  in  1  write response valid
- c1_rsp_mdata  in  MDATA_W  write response tag
- busy  out  1  write in flight
- wr_complete  out  1  one-cycle pulse when matching response accepted
- no_dsm_err  out  1  sticky: run_done seen while hc_dsm_base == 0

Behaviour:
- Reset values:
  - c1_req_valid=0, busy=0, wr_complete=0, no_dsm_err=0
  - tag=0, cycle counter=0, overrun=0, state IDLE
  - addr/mdata/data outputs = 0
- Cycle counter:
  - cleared to 0 on run_start, otherwise increments by 1 each cycle while counting; saturates at all-ones.
  - Counting begins on run_start and stops on run_done.
  - run_start and run_done in the same cycle: counter = 0 latched.
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - On run_done with hc_dsm_base != 0: latch err_count, fail_flag, counter value, hc_dsm_base; go to ISSUE.
  - With hc_dsm_base == 0: set no_dsm_err, stay IDLE, no write.
- ISSUE:
  - If c1_almfull=0: assert c1_req_valid for exactly one cycle with addr = latched base, mdata = tag, data as below; go to WAIT_RSP.
  - If c1_almfull=1: hold, no request.
- WAIT_RSP:
  - On c1_rsp_valid with c1_rsp_mdata == tag: pulse wr_complete next cycle, tag <= tag+1 (wraps modulo 2^MDATA_W), go to IDLE.
  - Responses with non-matching tag are ignored (stale traffic after reset).
- busy = state != IDLE.
- Status line layout:
  - data[31:0] = 32'h0000_0001 (done marker)
  - data[63:32] = err_count
  - data[64] = fail_flag
  - data[65] = overrun
  - data[127:66] = 0
  - data[191:128] = cycle count
  - rest 0
- overrun:
  - set if run_done arrives while busy; that run_done is otherwise ignored (not queued).
  - Reported in the next status line, then cleared when that line is issued.
- Latency: run_done at cycle T with almfull low → c1_req_valid at T+2.
- hc_dsm_base changing mid-operation has no effect on an issued or pending write (latched value used).
- Reset mid-operation:
  - returns to IDLE and drops pending state; tag resets to 0.
  - A late response carrying the old tag is ignored unless it coincidentally equals the new pending tag; software must not reset with writes in flight.
- run_start while busy: restarts the counter; the in-flight line is unaffected.

Test Plan:
- Base: hc_dsm_base=0x1000, run_start, then run_done 100 cycles later with err_count=5, fail=0 → one c1 request at run_done+2 with addr=0x1000, mdata=0, data[31:0]=1, data[63:32]=5, data[191:128]=100; response tag 0 → wr_complete pulse, busy low.
- c1_almfull held high 20 cycles after run_done → no request while high; a single request on the first cycle almfull=0.
- Response with mdata=3 while waiting on tag 0 → ignored, busy stays 1; then mdata=0 → wr_complete. Second job uses mdata=1.
- hc_dsm_base=0 and run_done → no c1_req_valid, no_dsm_err=1 and stays 1 until reset.
- Second run_done during WAIT_RSP → no second request; the next job's line has data[65]=1; the following line has data[65]=0.
- Reset asserted in WAIT_RSP → all outputs return to reset values next cycle; a late response with mdata=0 arriving while IDLE produces no wr_complete.

Source files
------------

// File: rtl/reed_solomon_decoder_dsm_writer.sv
// reed_solomon_decoder_dsm_writer: writes one 64-byte status line to the DSM on decoder completion
// and tracks the run cycle count, write tag and completion handshake.
module reed_solomon_decoder_dsm_writer #(
    parameter int MDATA_W = 16,
    parameter int ADDR_W  = 42,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  hc_dsm_base,
    input  logic               run_start,
    input  logic               run_done,
    input  logic [31:0]        err_count,
    input  logic               fail_flag,
    input  logic               c1_almfull,
    output logic               c1_req_valid,
    output logic [ADDR_W-1:0]  c1_req_addr,
    output logic [MDATA_W-1:0] c1_req_mdata,
    output logic [511:0]       c1_req_data,
    input  logic               c1_rsp_valid,
    input  logic [MDATA_W-1:0] c1_rsp_mdata,
    output logic               busy,
    output logic               wr_complete,
    output logic               no_dsm_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_lat;
    logic [63:0] cnt_ext;
    logic counting, overrun, fail_lat, issue;
    logic [31:0] err_lat;
    logic [ADDR_W-1:0] base_lat;
    logic [MDATA_W-1:0] tag;
    // The value latched on run_done already includes that cycle's increment.
    always_comb begin
        cnt_nxt = run_start ? '0 : (counting && !(&cnt)) ? cnt + 1'b1 : cnt;
        issue = state == ISSUE && !c1_almfull;
        cnt_ext = 64'(cnt_lat);
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            cnt_lat <= '0;
            counting <= 1'b0;
            overrun <= 1'b0;
            fail_lat <= 1'b0;
            err_lat <= '0;
            base_lat <= '0;
            tag <= '0;
            c1_req_valid <= 1'b0;
            c1_req_addr <= '0;
            c1_req_mdata <= '0;
            c1_req_data <= '0;
            wr_complete <= 1'b0;
            no_dsm_err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            counting <= run_start ? !run_done : counting && !run_done;
            overrun <= (run_done && busy) || (overrun && !issue);
            no_dsm_err <= no_dsm_err || (run_done && hc_dsm_base == '0);
            c1_req_valid <= issue;
            wr_complete <= 1'b0;
            case (state)
                IDLE: if (run_done && hc_dsm_base != '0) begin
                    err_lat <= err_count;
                    fail_lat <= fail_flag;
                    cnt_lat <= cnt_nxt;
                    base_lat <= hc_dsm_base;
                    state <= ISSUE;
                end
                ISSUE: if (!c1_almfull) begin
                    c1_req_addr <= base_lat;
                    c1_req_mdata <= tag;
                    c1_req_data <= {320'b0, cnt_ext, 62'b0, overrun, fail_lat, err_lat, 32'h0000_0001};
                    state <= WAIT_RSP;
                end
                WAIT_RSP: if (c1_rsp_valid && c1_rsp_mdata == tag) begin
                    wr_complete <= 1'b1;
                    tag <= tag + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reed_solomon_decoder_dsm_writer.sv
// tb_reed_solomon_decoder_dsm_writer: table-driven jobs, directed corner sequences and a
// randomized run against a timestamp-based reference model.
module tb_reed_solomon_decoder_dsm_writer;
    logic clk = 1'b0, reset = 1'b1;
    logic [41:0] hc_dsm_base = '0;
    logic run_start = 1'b0, run_done = 1'b0, fail_flag = 1'b0, c1_almfull = 1'b0;
    logic [31:0] err_count = '0;
    logic c1_req_valid, busy, wr_complete, no_dsm_err;
    logic [41:0] c1_req_addr;
    logic [15:0] c1_req_mdata;
    logic [511:0] c1_req_data;
    logic c1_rsp_valid = 1'b0;
    logic [15:0] c1_rsp_mdata = '0;
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    reed_solomon_decoder_dsm_writer dut (
        .clk(clk), .reset(reset), .hc_dsm_base(hc_dsm_base), .run_start(run_start),
        .run_done(run_done), .err_count(err_count), .fail_flag(fail_flag),
        .c1_almfull(c1_almfull), .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr),
        .c1_req_mdata(c1_req_mdata), .c1_req_data(c1_req_data), .c1_rsp_valid(c1_rsp_valid),
        .c1_rsp_mdata(c1_rsp_mdata), .busy(busy), .wr_complete(wr_complete),
        .no_dsm_err(no_dsm_err)
    );

    typedef struct {
        logic [41:0] base;
        int          gap;
        logic [31:0] err;
        logic        fail;
        int          alm;
        logic [15:0] mdata;
        logic [63:0] cnt;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] line(input logic [31:0] err, input logic fail,
                                          input logic ovr, input logic [63:0] cnt);
        logic [511:0] e;
        e = '0;
        e[31:0] = 32'h0000_0001;
        e[63:32] = err;
        e[64] = fail;
        e[65] = ovr;
        e[191:128] = cnt;
        return e;
    endfunction

    task automatic run_job(input logic [41:0] base, input int gap, input logic [31:0] err,
                           input logic fail);
        hc_dsm_base = base;
        err_count = err;
        fail_flag = fail;
        run_start = 1'b1;
        if (gap == 0) run_done = 1'b1;
        tick();
        run_start = 1'b0;
        run_done = 1'b0;
        if (gap > 0) begin
            repeat (gap - 1) tick();
            run_done = 1'b1;
            tick();
            run_done = 1'b0;
        end
    endtask

    task automatic respond(input logic [15:0] t);
        c1_rsp_valid = 1'b1;
        c1_rsp_mdata = t;
        tick();
        c1_rsp_valid = 1'b0;
    endtask

    // Runs one job and checks the single request it produces (latency, address, tag, line).
    task automatic job_expect(input string nm, input logic [41:0] base, input int gap,
                              input logic [31:0] err, input logic fail, input int alm,
                              input logic [15:0] mdata, input logic ovr, input logic [63:0] cnt);
        int n;
        logic seen;
        run_job(base, gap, err, fail);
        seen = 1'b0;
        n = 0;
        c1_almfull = alm > 0;
        repeat (alm) begin
            tick();
            n++;
            seen |= c1_req_valid;
        end
        c1_almfull = 1'b0;
        if (alm > 0) chk({nm, "_almfull_hold"}, seen, 1'b0);
        while (!c1_req_valid && n < 60) begin
            tick();
            n++;
        end
        chk({nm, "_req_seen"}, c1_req_valid, 1'b1);
        chk({nm, "_latency"}, n, alm + 1);
        chk({nm, "_addr"}, c1_req_addr, base);
        chk({nm, "_mdata"}, c1_req_mdata, mdata);
        chk({nm, "_data"}, c1_req_data, line(err, fail, ovr, cnt));
        tick();
        chk({nm, "_req_single"}, c1_req_valid, 1'b0);
        chk({nm, "_busy_wait"}, busy, 1'b1);
    endtask

    // Reference model state for the randomized run (timestamps, not a counter register).
    logic m_pend, m_wait, m_ovr, m_nodsm, m_fail, m_counting;
    logic [15:0] m_tag;
    logic [41:0] m_base;
    logic [31:0] m_err;
    logic [63:0] m_cnt, m_frozen;
    int m_start;

    initial begin
        logic seen;
        tbl[0] = '{42'h1000, 100, 32'd5, 1'b0, 0, 16'd0, 64'd100};
        tbl[1] = '{42'h2_0000_0040, 7, 32'hdead_beef, 1'b1, 20, 16'd1, 64'd7};
        tbl[2] = '{42'h3FF_FFFF_FFFF, 1, 32'd1, 1'b0, 3, 16'd2, 64'd1};
        tbl[3] = '{42'h55, 0, 32'hffff_ffff, 1'b1, 0, 16'd3, 64'd0};
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_valid", c1_req_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wrc", wr_complete, 1'b0);
        chk("rst_nodsm", no_dsm_err, 1'b0);
        chk("rst_data", {c1_req_addr, c1_req_mdata, c1_req_data}, '0);

        for (int i = 0; i < 4; i++) begin
            job_expect($sformatf("tbl%0d", i), tbl[i].base, tbl[i].gap, tbl[i].err,
                       tbl[i].fail, tbl[i].alm, tbl[i].mdata, 1'b0, tbl[i].cnt);
            respond(tbl[i].mdata);
            chk("tbl_wrc", wr_complete, 1'b1);
            chk("tbl_busy_done", busy, 1'b0);
            tick();
            chk("tbl_wrc_pulse", wr_complete, 1'b0);
        end

        job_expect("stale", 42'h1000, 10, 32'd9, 1'b0, 0, 16'd4, 1'b0, 64'd10);
        respond(16'd7);
        chk("stale_wrc", wr_complete, 1'b0);
        chk("stale_busy", busy, 1'b1);
        tick();
        chk("stale_busy2", busy, 1'b1);
        respond(16'd4);
        chk("stale_match_wrc", wr_complete, 1'b1);

        job_expect("ovr_a", 42'h1000, 12, 32'd2, 1'b0, 0, 16'd5, 1'b0, 64'd12);
        hc_dsm_base = 42'h777;
        run_done = 1'b1;
        tick();
        run_done = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen |= c1_req_valid;
        end
        chk("ovr_no_second_req", seen, 1'b0);
        respond(16'd5);
        chk("ovr_a_wrc", wr_complete, 1'b1);
        job_expect("ovr_b", 42'h2000, 4, 32'd3, 1'b1, 0, 16'd6, 1'b1, 64'd4);
        respond(16'd6);
        job_expect("ovr_c", 42'h3000, 6, 32'd8, 1'b0, 2, 16'd7, 1'b0, 64'd6);
        respond(16'd7);

        run_job(42'h0, 10, 32'd1, 1'b0);
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen |= c1_req_valid;
        end
        chk("nodsm_no_req", seen, 1'b0);
        chk("nodsm_flag", no_dsm_err, 1'b1);
        chk("nodsm_busy", busy, 1'b0);
        job_expect("nodsm_next", 42'h1000, 3, 32'd4, 1'b0, 0, 16'd8, 1'b0, 64'd3);
        respond(16'd8);
        chk("nodsm_sticky", no_dsm_err, 1'b1);

        job_expect("rstw", 42'h1000, 5, 32'd6, 1'b1, 0, 16'd9, 1'b0, 64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_valid", c1_req_valid, 1'b0);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_nodsm", no_dsm_err, 1'b0);
        chk("rstw_outs", {c1_req_addr, c1_req_mdata, c1_req_data}, '0);
        respond(16'd0);
        chk("rstw_late0_wrc", wr_complete, 1'b0);
        respond(16'd9);
        chk("rstw_late9_wrc", wr_complete, 1'b0);
        chk("rstw_idle", busy, 1'b0);
        job_expect("rstw_next", 42'h1000, 5, 32'd6, 1'b0, 0, 16'd0, 1'b0, 64'd5);
        respond(16'd0);
        chk("rstw_next_wrc", wr_complete, 1'b1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        {m_pend, m_wait, m_ovr, m_nodsm, m_fail, m_counting} = '0;
        m_tag = '0;
        m_base = '0;
        m_err = '0;
        m_cnt = '0;
        m_frozen = '0;
        m_start = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [63:0] b64, cval;
            logic rs, rd, alm, rv, busy_c, e_issue, e_wc;
            logic [15:0] md;
            logic [41:0] base;
            logic [31:0] err;
            logic fail;
            logic [511:0] e_data;
            logic [41:0] e_addr;
            logic [15:0] e_md;
            int r;
            rs = $urandom_range(99) < 3;
            rd = $urandom_range(99) < 4;
            alm = $urandom_range(99) < 30;
            b64 = {$urandom(), $urandom()};
            base = ($urandom_range(19) == 0) ? 42'h0 : b64[41:0];
            err = $urandom();
            fail = 1'($urandom_range(1));
            r = $urandom_range(99);
            rv = m_wait ? r < 30 : r < 3;
            md = (m_wait && r < 25) ? m_tag : m_wait ? m_tag + 16'd1 + 16'($urandom_range(5)) : 16'($urandom());
            {run_start, run_done, c1_almfull, hc_dsm_base, err_count, fail_flag} = {rs, rd, alm, base, err, fail};
            {c1_rsp_valid, c1_rsp_mdata} = {rv, md};
            busy_c = m_pend || m_wait;
            e_issue = m_pend && !alm;
            e_data = line(m_err, m_fail, m_ovr, m_cnt);
            e_addr = m_base;
            e_md = m_tag;
            e_wc = m_wait && rv && md == m_tag;
            cval = rs ? 64'd0 : m_counting ? 64'(c - m_start) : m_frozen;
            if (e_issue) begin
                m_pend = 1'b0;
                m_wait = 1'b1;
            end
            m_ovr = (rd && busy_c) || (m_ovr && !e_issue);
            if (e_wc) begin
                m_wait = 1'b0;
                m_tag = m_tag + 16'd1;
            end
            if (rd && !busy_c && base != '0) begin
                m_pend = 1'b1;
                {m_base, m_err, m_fail, m_cnt} = {base, err, fail, cval};
            end
            if (rd && base == '0) m_nodsm = 1'b1;
            if (rs) begin
                m_start = c;
                m_counting = !rd;
                m_frozen = '0;
            end else if (rd) begin
                m_frozen = cval;
                m_counting = 1'b0;
            end
            tick();
            chk("rnd_req_valid", c1_req_valid, e_issue);
            if (e_issue) begin
                chk("rnd_addr", c1_req_addr, e_addr);
                chk("rnd_mdata", c1_req_mdata, e_md);
                chk("rnd_data", c1_req_data, e_data);
            end
            chk("rnd_wrc", wr_complete, e_wc);
            chk("rnd_busy", busy, m_pend || m_wait);
            chk("rnd_nodsm", no_dsm_err, m_nodsm);
        end
        {run_start, run_done, c1_almfull, c1_rsp_valid} = '0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
